// File: rtl/gamma_sequencer.sv
// gamma_sequencer: owns the gamma LFSR, XOR-codes accepted words with the extended gamma, sequences one message per start
module gamma_sequencer #(
  parameter int SIZE = 4,
  parameter logic [SIZE-1:0] TAPS = 4'b1001,
  parameter int LEN_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [SIZE-1:0] seed,
  input  logic [LEN_W-1:0] msg_len,
  input  logic abort,
  output logic [SIZE-1:0] lst_rand,
  input  logic [2*SIZE-1:0] gamma_in,
  input  logic in_valid,
  input  logic [2*SIZE-1:0] in_data,
  output logic in_ready,
  output logic out_valid,
  output logic [2*SIZE-1:0] out_data,
  input  logic out_ready,
  output logic busy,
  output logic done,
  output logic [LEN_W-1:0] word_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [SIZE-1:0] lfsr_q;
  logic [LEN_W-1:0] len_q;
  logic go, load, accept, last, drained;
  assign lst_rand = lfsr_q;
  assign busy = state != IDLE;
  // Handshake qualifiers and next state; abort overrides start and accept
  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    go = start && !abort && state == IDLE;
    load = go && msg_len != '0;
    accept = in_valid && in_ready && !abort;
    last = accept && (word_cnt + LEN_W'(1) == len_q);
    drained = state == DRAIN && out_valid && out_ready;
    state_n = abort ? IDLE : load ? RUN : last ? DRAIN : drained ? IDLE : state;
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // LFSR, counters and output register; LFSR advances only on an accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SIZE'(1);
      len_q <= '0;
      word_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
    end else begin
      done <= !abort && ((go && msg_len == '0) || drained);
      out_valid <= abort ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (load) begin
        lfsr_q <= (seed == '0) ? SIZE'(1) : seed;
        len_q <= msg_len;
        word_cnt <= '0;
      end else if (accept) begin
        out_data <= in_data ^ gamma_in;
        lfsr_q <= {lfsr_q[SIZE-2:0], ^(lfsr_q & TAPS)};
        word_cnt <= (word_cnt == len_q) ? word_cnt : word_cnt + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_gamma_sequencer.sv
// tb_gamma_sequencer: randomized scoreboard bench for gamma_sequencer with a transaction-level model
module tb_gamma_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0, out_ready = 0;
  logic [3:0] seed = 0, lst_rand;
  logic [7:0] msg_len = 0, in_data = 0, gamma_in, out_data, word_cnt;
  logic in_ready, out_valid, busy, done;
  int errors = 0, checks = 0;
  logic [7:0] sb[$], seen[$];
  logic [7:0] e;
  int m_st;
  logic [3:0] m_lfsr;
  logic [7:0] m_cnt, m_len;
  bit m_ov;

  assign gamma_in = {lst_rand, lst_rand};

  gamma_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .msg_len(msg_len), .abort(abort),
    .lst_rand(lst_rand), .gamma_in(gamma_in), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] l);
    int fb;
    fb = ((l >> 3) & 1) ^ (l & 1);
    return 4'(((l * 2) + fb) % 16);
  endfunction

  task automatic model_reset();
    m_st = 0; m_lfsr = 4'h1; m_cnt = 0; m_len = 0; m_ov = 0;
  endtask

  // Sink side: pop and compare whenever a coded word is handed over
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        seen.push_back(out_data);
        chk("out_data", out_data, e);
      end
    end

  task automatic drv(input bit st, input logic [3:0] sd, input logic [7:0] ln, input bit ab,
                     input bit iv, input logic [7:0] id, input bit ordy);
    bit exp_rdy, acc, n_done;
    start = st; seed = sd; msg_len = ln; abort = ab; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    exp_rdy = (m_st == 1) && (!m_ov || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy && !ab;
    if (acc) sb.push_back(id ^ {m_lfsr, m_lfsr});
    n_done = 0;
    if (ab) begin
      if (m_ov && !ordy) sb.delete();
      m_st = 0; m_ov = 0;
    end else begin
      if (st && m_st == 0) begin
        if (ln == 0) n_done = 1;
        else begin m_st = 1; m_lfsr = (sd == 0) ? 4'h1 : sd; m_cnt = 0; m_len = ln; end
      end else if (acc) begin
        m_lfsr = nxt(m_lfsr);
        m_cnt++;
        if (m_cnt == m_len) m_st = 2;
      end else if (m_st == 2 && m_ov && ordy) begin
        m_st = 0; n_done = 1;
      end
      m_ov = acc ? 1'b1 : ordy ? 1'b0 : m_ov;
    end
    @(posedge clk); #1;
    chk("done", done, n_done);
    chk("busy", busy, m_st != 0);
    chk("word_cnt", word_cnt, m_cnt);
    chk("lst_rand", lst_rand, m_lfsr);
    chk("out_valid", out_valid, m_ov);
  endtask

  task automatic finish_msg(input int vp, input int rp, input bit rd, input logic [7:0] dc,
                            input int ap, input int sp);
    int c;
    for (c = 0; c < 400 && m_st != 0; c++)
      drv($urandom_range(99) < sp, 4'($urandom), 8'($urandom), $urandom_range(99) < ap,
          $urandom_range(99) < vp, rd ? 8'($urandom) : dc, $urandom_range(99) < rp);
    if (m_st != 0) chk("msg_timeout", c, 0);
  endtask

  task automatic run_msg(input logic [3:0] sd, input logic [7:0] ln, input int vp, input int rp,
                         input bit rd, input logic [7:0] dc, input int ap, input int sp);
    drv(1, sd, ln, 0, 0, 0, 1);
    finish_msg(vp, rp, rd, dc, ap, sp);
  endtask

  task automatic chk_basic_seq();
    logic [7:0] ref_seq [4];
    ref_seq = '{8'h11, 8'h33, 8'h77, 8'hFF};
    chk("seq_len", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("seq_val", seen[i], ref_seq[i]);
    chk("final_cnt", word_cnt, 4);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lst_rand", lst_rand, 1);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    // basic run
    seen.delete();
    run_msg(4'h1, 4, 100, 100, 0, 8'h00, 0, 0);
    chk_basic_seq();
    // backpressure after the first output
    seen.delete();
    drv(1, 4'h1, 4, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 0, 1);
    repeat (3) begin
      drv(0, 0, 0, 0, 1, 0, 0);
      chk("stall_data", out_data, 8'h11);
      chk("stall_lfsr", lst_rand, 4'h3);
    end
    finish_msg(100, 100, 0, 8'h00, 0, 0);
    chk_basic_seq();
    // zero seed guard
    seen.delete();
    drv(1, 4'h0, 1, 0, 0, 0, 1);
    chk("zero_seed", lst_rand, 4'h1);
    finish_msg(100, 100, 0, 8'hA5, 0, 0);
    chk("zero_seed_cnt", seen.size(), 1);
    if (seen.size() > 0) chk("zero_seed_out", seen[0], 8'hB4);
    // abort after three accepts, then an immediate restart
    drv(1, 4'h9, 10, 0, 0, 0, 1);
    repeat (3) drv(0, 0, 0, 0, 1, 8'($urandom), 1);
    drv(0, 0, 0, 1, 1, 8'($urandom), 1);
    chk("abort_busy", busy, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_cnt", word_cnt, 3);
    drv(1, 4'h6, 3, 0, 0, 0, 1);
    chk("restart_busy", busy, 1);
    finish_msg(80, 80, 1, 0, 0, 0);
    // zero length, then starts ignored while running
    drv(1, 4'h5, 0, 0, 0, 0, 1);
    chk("zero_len_done", done, 1);
    chk("zero_len_busy", busy, 0);
    run_msg(4'hC, 8, 80, 80, 1, 0, 0, 40);
    // randomized messages with occasional aborts and stray starts
    for (int i = 0; i < 40; i++)
      run_msg(4'($urandom), 8'($urandom_range(1, 12)), 70, 70, 1, 0, 2, 10);
    chk("sb_empty", sb.size(), 0);
    // async reset while draining with a word pending
    drv(1, 4'h7, 1, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 8'h3C, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_drain", busy && out_valid, 1);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_word_cnt", word_cnt, 0);
    chk("arst_lst_rand", lst_rand, 1);
    chk("arst_done", done, 0);
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    run_msg(4'h2, 5, 90, 90, 1, 0, 0, 0);
    chk("sb_final", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
